mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory controller between the EX/MEM and MEM/WB pipeline registers.
- Accepts the load/store request carried in EX/MEM (control bits, ALU address, store data) and drives a req/ack data-RAM port.
- Byte-lane steers stores; aligns and sign/zero-extends load data into MemDout, which the MEM/WB register captures.
- Stalls the pipeline while the RAM access is outstanding.

Parameters:
- TIMEOUT, 255: max BUSY cycles waiting for mem_ack before the access is abandoned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- M  in  2  [1]=MemRead, [0]=MemWrite, from EX/MEM.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- ALU  in  32  byte address.
- wdata  in  32  store data (rt).
- MemDout  out  32  aligned load result to MEM/WB.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- misalign  out  1  misaligned access, current cycle.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  RAM request.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  word-aligned address ({ALU[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read data, valid with mem_ack.
- mem_ack  in  1  RAM completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; the timeout counter clears.
  - MemDout, mem_req, mem_we, mem_addr, mem_be, mem_wdata and bus_err all go to 0.
  - stall and misalign are forced to 0 while reset is asserted.
  - Reset during BUSY drops mem_req immediately. The pending access is discarded and a late mem_ack is ignored.
- Access definition:
  - access = M!=0.
  - Misaligned = half with ALU[0]=1, or word with ALU[1:0]!=0.
  - M=11 is a write only; MemDout is not updated.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Aligned access: stall=1 combinationally. At the edge, register mem_addr, mem_we=M[0], mem_be and mem_wdata, set mem_req=1, clear the counter, and go to BUSY.
  - Misaligned access: misalign=1 and stall=0 combinationally, no RAM request, and MemDout<=0 at the edge.
  - No access: MemDout holds its value.
- BUSY:
  - stall=1. mem_req and the address, data and enable outputs are held stable until mem_ack=1 is sampled.
  - On ack: mem_req<=0, mem_we<=0; on a read, MemDout<=extracted data; go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 without ack: mem_req<=0, MemDout<=32'hFFFFFFFF, bus_err=1 for one cycle, go to DONE.
  - Ack and timeout on the same edge: ack wins.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances and MEM/WB captures MemDout.
  - Next state is IDLE; the new EX/MEM contents are evaluated there.
  - mem_ack seen in IDLE or DONE is ignored.
- Minimum load/store: 2 stall cycles (IDLE plus one BUSY cycle) when ack arrives in the first BUSY cycle.
- Store lanes (o=ALU[1:0]):
  - Byte: mem_be=4'b0001<<o, mem_wdata={4{wdata[7:0]}}.
  - Half: mem_be=4'b0011<<o, mem_wdata={2{wdata[15:0]}}.
  - Word: mem_be=4'b1111, mem_wdata=wdata.
- Load extraction:
  - Byte: mem_rdata[8o+7:8o].
  - Half: mem_rdata[16*ALU[1]+15:16*ALU[1]].
  - Extension per load_unsigned, latched at IDLE with the address.
- Inputs may change during BUSY. All access attributes come from the values latched at IDLE.

Test Plan:
- Word load, ALU=0x100, RAM acks the first BUSY cycle with 0xCAFEBABE -> mem_addr=0x100, be=1111, we=0; stall high 2 cycles; MemDout=0xCAFEBABE in the DONE cycle.
- Byte load signed, ALU=0x203, rdata=0x80FF1234 -> be=1000, MemDout=0xFFFFFF80. Same with load_unsigned=1 -> MemDout=0x00000080.
- Half store, ALU=0x302, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; MemDout unchanged.
- Misaligned word load, ALU=0x101 -> misalign=1, stall=0, mem_req stays 0, MemDout=0.
- TIMEOUT=4, ack never asserted -> mem_req high 4 cycles, then bus_err pulse, MemDout=0xFFFFFFFF, DONE, stall drops.
- reset=0 mid-BUSY, then a late ack -> mem_req=0 immediately, state IDLE, all outputs 0, late ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: steers stores onto a req/ack RAM port, aligns and
// extends load data into MemDout, and stalls the pipeline while an access is outstanding.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] ALU,
    input  logic [31:0] wdata,
    output logic [31:0] MemDout,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    size_r;
    logic [1:0]    off_r;
    logic          uns_r;
    logic          rd_r;
    logic [31:0]   dout_r;
    logic          bus_err_r;
    logic          req_r;
    logic          we_r;
    logic [31:0]   addr_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;
    logic          access_s;
    logic          mis_s;
    logic          stall_s;
    logic          misalign_s;

    // Classify the EX/MEM request and derive the combinational stall/misalign flags.
    always_comb begin
        access_s   = (M != 2'b00);
        mis_s      = 1'b0;
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        case (size)
            2'b00:   mis_s = 1'b0;
            2'b01:   mis_s = ALU[0];
            default: mis_s = (ALU[1:0] != 2'b00);
        endcase
        case (state_r)
            IDLE: begin
                stall_s    = access_s & ~mis_s;
                misalign_s = access_s & mis_s;
            end
            BUSY:    stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM; all attributes are latched at IDLE so EX/MEM may change while BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            size_r    <= 2'b00;
            off_r     <= 2'b00;
            uns_r     <= 1'b0;
            rd_r      <= 1'b0;
            dout_r    <= 32'h0000_0000;
            bus_err_r <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 32'h0000_0000;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
        end else begin
            bus_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (access_s && mis_s) begin
                        dout_r <= 32'h0000_0000;
                    end else if (access_s) begin
                        size_r  <= size;
                        off_r   <= ALU[1:0];
                        uns_r   <= load_unsigned;
                        rd_r    <= (M == 2'b10);
                        addr_r  <= {ALU[31:2], 2'b00};
                        we_r    <= M[0];
                        be_r    <= lane_be(size, ALU[1:0]);
                        wdata_r <= lane_data(size, wdata);
                        req_r   <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        if (rd_r) begin
                            dout_r <= load_align(mem_rdata, size_r, off_r, uns_r);
                        end
                        state_r <= DONE;
                    end else if (cnt_r == LAST_CNT) begin
                        req_r     <= 1'b0;
                        we_r      <= 1'b0;
                        dout_r    <= 32'hFFFF_FFFF;
                        bus_err_r <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign stall     = reset & stall_s;
    assign misalign  = reset & misalign_s;
    assign MemDout   = dout_r;
    assign bus_err   = bus_err_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_be    = be_r;
    assign mem_wdata = wdata_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected MemDout values are queued when an access
// is driven and popped when the DUT reaches its completion (DONE) cycle.
module tb_mem_access_unit;
    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  M;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] ALU;
    logic [31:0] wdata;
    logic [31:0] MemDout;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_dout = 32'h0000_0000;

    mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .M(M), .size(size), .load_unsigned(load_unsigned),
        .ALU(ALU), .wdata(wdata), .MemDout(MemDout), .stall(stall), .misalign(misalign),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One aligned access from IDLE through DONE; ack_at is the BUSY cycle that acks, -1 = never.
    task automatic run_access(input string tag, input logic [1:0] m, input logic [1:0] sz,
                              input logic lu, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_dout);
        int   n_stall;
        int   req_cycles;
        logic done;
        logic [31:0] got;
        M = m; size = sz; load_unsigned = lu; ALU = a; wdata = wd;
        exp_q.push_back(exp_dout);
        #1;
        check_val({tag, "_stall_idle"}, 32'(stall), 32'd1);
        n_stall = 1;
        @(posedge clk); #1;
        check_val({tag, "_req"}, 32'(mem_req), 32'd1);
        check_val({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        check_val({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        check_val({tag, "_we"}, 32'(mem_we), 32'(m[0]));
        check_val({tag, "_wdata"}, mem_wdata, exp_wd);
        M = 2'b00; size = ~sz; load_unsigned = ~lu; ALU = ~a; wdata = ~wd;
        req_cycles = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (stall) n_stall++;
            if (mem_req) req_cycles++;
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rd : ~rd;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_req) done = 1'b1;
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_stall_done"}, 32'(stall), 32'd0);
        got = 32'hDEAD_0000;
        if (exp_q.size() == 0) check_val({tag, "_queue"}, 32'd0, 32'd1);
        else check_val({tag, "_dout"}, MemDout, exp_q.pop_front());
        check_val({tag, "_bus_err"}, 32'(bus_err), (ack_at < 0) ? 32'd1 : 32'd0);
        check_val({tag, "_we_done"}, 32'(mem_we), 32'd0);
        check_val({tag, "_nstall"}, 32'(n_stall), (ack_at < 0) ? 32'(TB_TIMEOUT + 1) : 32'(ack_at + 2));
        check_val({tag, "_nreq"}, 32'(req_cycles), (ack_at < 0) ? 32'(TB_TIMEOUT) : 32'(ack_at + 1));
        last_dout = exp_dout;
        @(posedge clk); #1;
        check_val({tag, "_bus_err_clr"}, 32'(bus_err), 32'd0);
    endtask

    task automatic run_misaligned(input string tag, input logic [1:0] sz, input logic [31:0] a);
        M = 2'b10; size = sz; load_unsigned = 1'b0; ALU = a;
        #1;
        check_val({tag, "_misalign"}, 32'(misalign), 32'd1);
        check_val({tag, "_stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_req"}, 32'(mem_req), 32'd0);
        check_val({tag, "_dout"}, MemDout, 32'h0000_0000);
        last_dout = 32'h0000_0000;
        M = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; M = 2'b00; size = 2'b00; load_unsigned = 1'b0;
        ALU = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout", MemDout, 32'h0);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_be", 32'(mem_be), 32'd0);
        check_val("rst_wdata", mem_wdata, 32'h0);
        check_val("rst_bus_err", 32'(bus_err), 32'd0);
        M = 2'b10; size = 2'b10; ALU = 32'h0000_0101;
        #1;
        check_val("rst_stall_forced", 32'(stall), 32'd0);
        check_val("rst_misalign_forced", 32'(misalign), 32'd0);
        M = 2'b00; ALU = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;

        run_access("ld_word", 2'b10, 2'b10, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, 0,
                   4'b1111, 32'h0, 32'hCAFE_BABE);
        run_access("ld_byte_s", 2'b10, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_1234, 0,
                   4'b1000, 32'h0, 32'hFFFF_FF80);
        run_access("ld_byte_u", 2'b10, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_1234, 2,
                   4'b1000, 32'h0, 32'h0000_0080);
        run_access("st_half", 2'b01, 2'b01, 1'b0, 32'h302, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
                   4'b1100, 32'hABCD_ABCD, last_dout);
        run_access("ld_half_s", 2'b10, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_7FFF, 1,
                   4'b1100, 32'h0, 32'hFFFF_8001);
        run_access("st_byte", 2'b01, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 32'h7777_7777, 0,
                   4'b0010, 32'h5A5A_5A5A, last_dout);
        run_access("st_m11", 2'b11, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF, 32'h1111_1111, 0,
                   4'b1111, 32'hDEAD_BEEF, last_dout);
        run_access("ld_size11", 2'b10, 2'b11, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 0,
                   4'b1111, 32'h0, 32'h1234_5678);
        run_misaligned("mis_word", 2'b10, 32'h101);
        run_access("ld_half_u", 2'b10, 2'b01, 1'b1, 32'h300, 32'h0, 32'h0000_9ABC, 0,
                   4'b0011, 32'h0, 32'h0000_9ABC);
        run_misaligned("mis_half", 2'b01, 32'h103);
        run_access("timeout", 2'b10, 2'b10, 1'b0, 32'h600, 32'h0, 32'h5555_5555, -1,
                   4'b1111, 32'h0, 32'hFFFF_FFFF);

        // Reset in the middle of BUSY, then a late ack that must be ignored.
        M = 2'b10; size = 2'b10; ALU = 32'h500;
        @(posedge clk); #1;
        check_val("rb_req_busy", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_val("rb_req", 32'(mem_req), 32'd0);
        check_val("rb_dout", MemDout, 32'h0);
        check_val("rb_stall", 32'(stall), 32'd0);
        check_val("rb_addr", mem_addr, 32'h0);
        check_val("rb_be", 32'(mem_be), 32'd0);
        #2;
        reset = 1'b1; M = 2'b00;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_val("late_ack_req", 32'(mem_req), 32'd0);
        check_val("late_ack_dout", MemDout, 32'h0);
        check_val("late_ack_stall", 32'(stall), 32'd0);
        check_val("late_ack_bus_err", 32'(bus_err), 32'd0);
        run_access("post_rst", 2'b10, 2'b10, 1'b0, 32'h700, 32'h0, 32'h0BAD_F00D, 0,
                   4'b1111, 32'h0, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
